// File: rtl/uart_serial_rx.sv
// uart_serial_rx: 8N1 asynchronous serial byte receiver feeding the move decoder.
// Synchronises rx and validates the start bit at mid-bit. Samples 8 data bits
// LSB-first at mid-bit, then checks the stop bit.
//   clk          system clock
//   rst          synchronous active-high reset
//   rx           asynchronous serial line, idle high
//   rx_data      last correctly framed byte (decoder: jugada=[2:0], confirmacion=[3])
//   rx_ready     one-cycle strobe, rx_data updated this cycle
//   frame_error  one-cycle strobe, stop bit sampled low
//   busy         high whenever the receiver is not in IDLE
// CLK_FREQ/BAUD_RATE must be >= 4.
module uart_serial_rx #(
   parameter int unsigned CLK_FREQ  = 50_000_000,
   parameter int unsigned BAUD_RATE = 9600
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx,
   output logic [7:0] rx_data,
   output logic       rx_ready,
   output logic       frame_error,
   output logic       busy
);

   localparam int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
   localparam int unsigned HALF         = CLKS_PER_BIT / 2;
   localparam int unsigned CNT_W        = $clog2(CLKS_PER_BIT);

   localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] HALF_LAST  = CNT_W'(HALF - 1);
   // Cycles to flush the reset value (1) out of the synchroniser before trusting rx_s
   localparam logic [CNT_W-1:0] FLUSH_LAST = CNT_W'(2);

   typedef enum logic [2:0] {
      WAIT_IDLE,
      IDLE,
      START,
      DATA,
      STOP
   } state_t;

   state_t           state, state_n;
   logic             rx_meta, rx_s;
   logic [CNT_W-1:0] cnt, cnt_n;
   logic [2:0]       bit_idx, bit_idx_n;
   logic [7:0]       shreg, shreg_n;
   logic [7:0]       rx_data_n;
   logic             rx_ready_n, frame_error_n, busy_n;

   // State, datapath and output registers, plus the 2-FF rx synchroniser
   always_ff @(posedge clk) begin
      if (rst) begin
         rx_meta     <= 1'b1;
         rx_s        <= 1'b1;
         state       <= WAIT_IDLE;
         cnt         <= '0;
         bit_idx     <= '0;
         shreg       <= '0;
         rx_data     <= 8'h00;
         rx_ready    <= 1'b0;
         frame_error <= 1'b0;
         busy        <= 1'b1;
      end else begin
         rx_meta     <= rx;
         rx_s        <= rx_meta;
         state       <= state_n;
         cnt         <= cnt_n;
         bit_idx     <= bit_idx_n;
         shreg       <= shreg_n;
         rx_data     <= rx_data_n;
         rx_ready    <= rx_ready_n;
         frame_error <= frame_error_n;
         busy        <= busy_n;
      end
   end

   // Next-state and next-output logic
   always_comb begin
      state_n       = state;
      cnt_n         = cnt;
      bit_idx_n     = bit_idx;
      shreg_n       = shreg;
      rx_data_n     = rx_data;
      rx_ready_n    = 1'b0;
      frame_error_n = 1'b0;

      case (state)
         WAIT_IDLE: begin
            // The synchroniser resets high, so a line held low through reset would
            // otherwise look idle for two cycles; wait out that flush before arming.
            if (cnt < FLUSH_LAST) begin
               cnt_n = cnt + CNT_W'(1);
            end else if (rx_s) begin
               cnt_n   = '0;
               state_n = IDLE;
            end
         end

         IDLE: begin
            cnt_n = '0;
            if (!rx_s) state_n = START;
         end

         START: begin
            if (cnt == HALF_LAST) begin
               cnt_n     = '0;
               bit_idx_n = '0;
               state_n   = rx_s ? IDLE : DATA;
            end else begin
               cnt_n = cnt + CNT_W'(1);
            end
         end

         DATA: begin
            if (cnt == CNT_LAST) begin
               cnt_n     = '0;
               shreg_n   = {rx_s, shreg[7:1]};
               bit_idx_n = bit_idx + 3'd1;
               if (bit_idx == 3'd7) state_n = STOP;
            end else begin
               cnt_n = cnt + CNT_W'(1);
            end
         end

         STOP: begin
            // Leave at mid stop bit so a start bit with zero idle gap is still caught
            if (cnt == CNT_LAST) begin
               cnt_n = '0;
               if (rx_s) begin
                  rx_data_n  = shreg;
                  rx_ready_n = 1'b1;
                  state_n    = IDLE;
               end else begin
                  frame_error_n = 1'b1;
                  state_n       = WAIT_IDLE;
               end
            end else begin
               cnt_n = cnt + CNT_W'(1);
            end
         end

         default: begin
            cnt_n   = '0;
            state_n = WAIT_IDLE;
         end
      endcase

      busy_n = (state_n != IDLE);
   end

endmodule
